ldvio_trainer: RTL and testbench
================================

// Module: ldvio_trainer
// PURPOSE
//  Write-side controller for the load-violation predictor table. Sits between the LSU
//    violation detector and the table's single write port (addr0wr/data0wr/we0).
//  The table has no reset. This block initialises it after reset, trains entries on
//    detected load violations, and periodically decays (clears) the whole table.
//  Dispatch reads the table directly. An entry predicts "violates" when data[WIDTH-1]=1
//    and the stored tag matches.
// PARAMETERS
//  DEPTH         16     table entries
//  INDEX         4      log2(DEPTH); table address width
//  WIDTH         8      table entry width: {valid, tag[WIDTH-2:0]}
//  PC_WIDTH      32     width of violating load PC
//  FIFO_DEPTH    4      pending-event queue entries (power of 2, >=2)
//  DECAY_PERIOD  65536  cycles between decay sweeps; 0 disables decay
// PORTS
//  clk              in   1         core clock
//  reset            in   1         asynchronous, active-high reset
//  violate_valid_i  in   1         LSU reports a load violation this cycle (no backpressure)
//  violate_pc_i     in   PC_WIDTH  PC of the violating load
//  addr0wr_o        out  INDEX     table write address
//  data0wr_o        out  WIDTH     table write data
//  we0_o            out  1         table write enable
//  init_done_o      out  1         table initialised; dispatch may trust reads
//  sweep_busy_o     out  1         INIT or DECAY sweep in progress
//  drop_cnt_o       out  16        saturating count of events dropped on full queue
// BEHAVIOUR
//  Reset values
//    FSM=INIT, sweep_ptr=0, FIFO empty, decay_cnt=0, decay_pend=0.
//    we0_o=0, addr0wr_o=0, data0wr_o=0, init_done_o=0, sweep_busy_o=1, drop_cnt_o=0.
//  Output registers
//    All outputs are registered; one table write at most per cycle.
//    Reset mid-operation aborts everything and restarts INIT.
//  Index and data
//    idx = pc[INDEX+1:2].
//    train data = {1'b1, pc[INDEX+2 +: WIDTH-1]}.
//    clear data = 0.
//  Event capture
//    violate_valid_i is sampled every cycle in every state.
//    Bypass: in IDLE, FIFO empty and no sweep starting -> the write goes straight to the
//      output register (we0_o=1 next cycle).
//    Otherwise the event is pushed to the FIFO.
//    FIFO full -> the event is pushed only if a pop happens the same cycle; otherwise it
//      is dropped and drop_cnt_o increments (saturates at 16'hFFFF).
//    Duplicate events are not merged.
//  FSM states
//    INIT
//      Each cycle writes clear data to sweep_ptr, then sweep_ptr++.
//      After the write with sweep_ptr=DEPTH-1 -> IDLE, sweep_ptr=0.
//      init_done_o=1 from the following cycle until the next reset.
//      Takes exactly DEPTH write cycles.
//    IDLE
//      decay_pend=1 -> DECAY (takes priority over the FIFO).
//      Else FIFO non-empty -> pop the oldest entry, train write next cycle.
//    DECAY
//      Same sweep as INIT, but init_done_o stays 1.
//      FIFO is not popped; events enqueue.
//      After the last entry -> IDLE, and the queued events drain in order.
//  Decay timer
//    decay_cnt increments every cycle except in INIT.
//    At decay_cnt==DECAY_PERIOD-1: decay_pend=1, decay_cnt=0.
//    decay_pend clears on entering DECAY.
//    DECAY_PERIOD=0: decay never fires.
//  sweep_busy_o = (state != IDLE).
//  Ordering
//    Train writes reach the table in arrival order.
//    An event arriving during a sweep is written after the sweep, so it survives that decay.
// TESTING
//  1. Reset, DEPTH=16 -> we0_o=1 with data 0 for cycles 1..16, addr 0..15;
//       init_done_o=1 at cycle 17.
//  2. IDLE, empty FIFO, violate pc=0x0000_1A34 -> next cycle addr0wr_o=0xD,
//       data0wr_o={1,pc[12:6]}=0xE8, we0_o=1.
//  3. 6 back-to-back events during INIT, FIFO_DEPTH=4 -> 4 queued, 2 dropped,
//       drop_cnt_o=2; the 4 writes follow INIT in arrival order.
//  4. DECAY_PERIOD=32, events arriving every cycle -> after 32 counted cycles, 16 clear
//       writes; queued events are written afterward; no event lost while the FIFO is not full.
//  5. Event pushed into a full FIFO on the same cycle as a pop -> accepted, drop_cnt_o unchanged.
//  6. Assert reset during DECAY at sweep_ptr=7 -> all outputs return to reset values;
//       INIT restarts at addr 0.

Source files
------------

// File: rtl/ldvio_trainer.sv
// Write-side controller for the load-violation predictor table: clears the table after reset,
// trains entries on load violations and periodically decays the whole table.
module ldvio_trainer #(
  parameter int DEPTH        = 16,
  parameter int INDEX        = 4,
  parameter int WIDTH        = 8,
  parameter int PC_WIDTH     = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int DECAY_PERIOD = 65536
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                violate_valid_i,
  input  logic [PC_WIDTH-1:0] violate_pc_i,
  output logic [INDEX-1:0]    addr0wr_o,
  output logic [WIDTH-1:0]    data0wr_o,
  output logic                we0_o,
  output logic                init_done_o,
  output logic                sweep_busy_o,
  output logic [15:0]         drop_cnt_o
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  typedef struct packed {
    logic [INDEX-1:0] idx;
    logic [WIDTH-1:0] data;
  } wr_t;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DECAY} state_t;

  state_t           state_q;
  logic [INDEX-1:0] sweep_ptr_q;
  logic [FAW:0]     wp_q, rp_q;
  logic [CW-1:0]    decay_cnt_q;
  logic             decay_pend_q;
  logic [INDEX-1:0] addr_q;
  logic [WIDTH-1:0] data_q;
  logic             we_q, init_done_q, busy_q;
  logic [15:0]      drop_q;
  wr_t              mem_q [FIFO_DEPTH];

  wr_t  ev, head;
  logic empty, full, pop, bypass, push, drop, fire;
  logic unused_pc_bits;

  assign ev.idx  = violate_pc_i[INDEX+1:2];
  assign ev.data = {1'b1, violate_pc_i[INDEX+2 +: WIDTH-1]};
  assign unused_pc_bits = ^{violate_pc_i[PC_WIDTH-1:INDEX+WIDTH+1], violate_pc_i[1:0]};

  assign head  = mem_q[rp_q[FAW-1:0]];
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FAW] != rp_q[FAW]) && (wp_q[FAW-1:0] == rp_q[FAW-1:0]);

  // A pending decay blocks both pop and bypass so nothing slips in ahead of the sweep.
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    if (state_q == S_IDLE && !decay_pend_q) begin
      pop    = !empty;
      bypass = empty && violate_valid_i;
    end
    push = violate_valid_i && !bypass && (!full || pop);
    drop = violate_valid_i && !bypass && full && !pop;
    fire = (DECAY_PERIOD != 0) && (state_q != S_INIT) &&
           (decay_cnt_q == CW'(DECAY_PERIOD-1));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[FAW-1:0]] <= ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      sweep_ptr_q  <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      decay_cnt_q  <= '0;
      decay_pend_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      drop_q       <= '0;
    end else begin
      we_q        <= 1'b0;
      init_done_q <= (state_q != S_INIT);
      if (pop)  rp_q <= rp_q + 1'b1;
      if (push) wp_q <= wp_q + 1'b1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;

      if (state_q != S_INIT) decay_cnt_q <= fire ? '0 : decay_cnt_q + 1'b1;
      if (fire)
        decay_pend_q <= 1'b1;
      else if (state_q == S_IDLE && decay_pend_q)
        decay_pend_q <= 1'b0;

      case (state_q)
        S_INIT, S_DECAY: begin
          we_q        <= 1'b1;
          addr_q      <= sweep_ptr_q;
          data_q      <= '0;
          sweep_ptr_q <= sweep_ptr_q + 1'b1;
          if (sweep_ptr_q == INDEX'(DEPTH-1)) begin
            state_q     <= S_IDLE;
            sweep_ptr_q <= '0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          if (decay_pend_q) begin
            state_q <= S_DECAY;
            busy_q  <= 1'b1;
          end else if (pop) begin
            we_q   <= 1'b1;
            addr_q <= head.idx;
            data_q <= head.data;
          end else if (bypass) begin
            we_q   <= 1'b1;
            addr_q <= ev.idx;
            data_q <= ev.data;
          end
        end
      endcase
    end
  end

  assign addr0wr_o    = addr_q;
  assign data0wr_o    = data_q;
  assign we0_o        = we_q;
  assign init_done_o  = init_done_q;
  assign sweep_busy_o = busy_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_ldvio_trainer.sv
// Randomized bench for ldvio_trainer against a queue-based reference model of the table writer.
module tb_ldvio_trainer;
  localparam int DEPTH = 16;
  localparam int FD    = 4;
  localparam int P     = 32;

  logic        clk, rst, vld;
  logic [31:0] pc;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        we, done, busy;
  logic [15:0] drops;

  ldvio_trainer #(.DEPTH(DEPTH), .INDEX(4), .WIDTH(8), .PC_WIDTH(32),
                  .FIFO_DEPTH(FD), .DECAY_PERIOD(P)) dut (
    .clk(clk), .reset(rst), .violate_valid_i(vld), .violate_pc_i(pc),
    .addr0wr_o(addr), .data0wr_o(data), .we0_o(we), .init_done_o(done),
    .sweep_busy_o(busy), .drop_cnt_o(drops));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a table entry write is (address, data).
  typedef struct { int a; int d; } wr_t;
  wr_t q[$];
  bit  m_init, m_dpend;
  int  m_left, m_dcnt, m_drops;
  bit  e_we, e_done, e_busy;
  int  e_addr, e_data;

  function automatic int f_idx(input logic [31:0] p);  return int'((p >> 2) & 32'hF); endfunction
  function automatic int f_dat(input logic [31:0] p);  return 128 + int'((p >> 6) & 32'h7F); endfunction

  task automatic m_reset();
    q.delete();
    m_init = 1; m_left = DEPTH; m_dcnt = 0; m_dpend = 0; m_drops = 0;
    e_we = 0; e_done = 0; e_busy = 1; e_addr = 0; e_data = 0;
  endtask

  task automatic m_step(input bit v, input logic [31:0] p);
    bit pre_init, isfull, byp, popd;
    wr_t w;
    pre_init = m_init; isfull = (q.size() == FD); byp = 0; popd = 0; e_we = 0;
    if (m_left > 0) begin
      e_we = 1; e_addr = DEPTH - m_left; e_data = 0;
      m_left--;
      if (m_left == 0) m_init = 0;
    end else if (m_dpend) begin
      m_left = DEPTH; m_dpend = 0;
    end else if (q.size() > 0) begin
      w = q.pop_front(); e_we = 1; e_addr = w.a; e_data = w.d; popd = 1;
    end else if (v) begin
      e_we = 1; e_addr = f_idx(p); e_data = f_dat(p); byp = 1;
    end
    if (v && !byp) begin
      if (!isfull || popd) begin
        w.a = f_idx(p); w.d = f_dat(p); q.push_back(w);
      end else if (m_drops < 65535) m_drops++;
    end
    if (!pre_init) begin
      if (m_dcnt == P-1) begin m_dcnt = 0; m_dpend = 1; end
      else m_dcnt++;
    end
    e_done = !pre_init;
    e_busy = (m_left > 0);
  endtask

  // Called at a negedge: drive, step through one posedge, compare at the next negedge.
  task automatic cyc(input bit v, input logic [31:0] p);
    vld = v; pc = p;
    @(posedge clk);
    m_step(v, p);
    @(negedge clk);
    chk("we", {31'd0, we}, {31'd0, e_we});
    if (e_we) begin
      chk("addr", {28'd0, addr}, e_addr);
      chk("data", {24'd0, data}, e_data);
    end
    chk("init_done", {31'd0, done}, {31'd0, e_done});
    chk("sweep_busy", {31'd0, busy}, {31'd0, e_busy});
    chk("drop_cnt", {16'd0, drops}, m_drops);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; vld = 0; pc = 0;
    m_reset();
    #1;
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_addr", {28'd0, addr}, 0);
    chk("rst_data", {24'd0, data}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_drop", {16'd0, drops}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  logic [31:0] saved [6];
  logic [31:0] pcx;
  bit found;

  initial begin
    rst = 0; vld = 0; pc = 0;
    #1 rst = 1;
    do_reset();

    // Initial sweep writes 0..15 then flags done one cycle later
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0);
      chk("init_we", {31'd0, we}, 1);
      chk("init_addr", {28'd0, addr}, i);
    end
    cyc(0, 0);
    chk("init_done17", {31'd0, done}, 1);

    // Bypass write straight from IDLE
    cyc(1, 32'h0000_1A34);
    chk("byp_addr", {28'd0, addr}, 32'hD);
    chk("byp_data", {24'd0, data}, 32'hE8);

    // Six events during INIT: four queued, two dropped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      saved[i] = $urandom;
      cyc(1, saved[i]);
    end
    for (int i = 6; i < DEPTH; i++) cyc(0, 0);
    chk("init_drops", {16'd0, drops}, 2);
    pcx = $urandom;
    cyc(1, pcx);  // full queue with a pop this cycle: accepted
    chk("fullpop_drop", {16'd0, drops}, 2);
    chk("q0_addr", {28'd0, addr}, f_idx(saved[0]));
    chk("q0_data", {24'd0, data}, f_dat(saved[0]));
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0);
      chk("qn_addr", {28'd0, addr}, f_idx(saved[i]));
      chk("qn_data", {24'd0, data}, f_dat(saved[i]));
    end
    cyc(0, 0);
    chk("qx_addr", {28'd0, addr}, f_idx(pcx));
    chk("qx_data", {24'd0, data}, f_dat(pcx));

    // Events every cycle across decay sweeps
    for (int i = 0; i < 120; i++) cyc(1, $urandom);
    // Mixed random traffic
    for (int i = 0; i < 300; i++) cyc(($urandom_range(0, 9) < 5), $urandom);

    // Reset in the middle of a decay sweep with sweep pointer at 7
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(($urandom_range(0, 9) < 3), $urandom);
      if (!m_init && m_left > 0 && (DEPTH - m_left) == 7) found = 1;
    end
    chk("decay_reached", {31'd0, found}, 1);
    chk("decay_busy", {31'd0, busy}, 1);
    chk("decay_done", {31'd0, done}, 1);
    do_reset();
    cyc(0, 0);
    chk("restart_addr", {28'd0, addr}, 0);
    chk("restart_we", {31'd0, we}, 1);
    for (int i = 1; i < DEPTH + 4; i++) cyc(($urandom_range(0, 1) == 1), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
